// File: rtl/cpu_pkg.sv
// Shared RV64 pipeline definitions: data widths, the NOP encoding, the default
// reset PC and the payload handed from fetch to decode.
package cpu_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] INST_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: EX redirect, instruction-memory request/response
// channel and the decode-side valid/ready slot.
//   master : the fetch stage
//   slave  : its environment (EX, instruction memory, decode)
interface inst_fetch_if;
    import cpu_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;

    logic            id_valid;
    logic            id_ready;
    logic [ILEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output id_valid, id_inst, id_pc,
        input  id_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  id_valid, id_inst, id_pc,
        output id_ready
    );

endinterface

// File: rtl/inst_fifo.sv
// Synchronous FIFO with flush, used as the fetch instruction buffer.
//   clk, rstn       : clock, async active-low reset
//   flush           : empties the FIFO; overrides push and pop that cycle
//   push, push_data : write one entry (caller guarantees no overflow)
//   pop             : drop the head entry (caller guarantees not empty)
//   occ             : registered occupancy
//   head            : entry at the read pointer (undefined when empty)
module inst_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 96
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic [WIDTH-1:0]             head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      occ <= occ + CW'(1);
            else if (!push && pop) occ <= occ - CW'(1);
        end
    end

    // Storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// RV64 instruction-fetch stage. Holds the PC, issues word reads on the imem
// request channel, buffers in-order responses and presents {inst, pc} to decode.
// EX redirects reload the PC, flush the buffer and discard in-flight responses.
//   clk, rstn : clock, async active-low reset
//   bus       : inst_fetch_if.master (redirect, imem req/resp, decode slot)
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    inst_fetch_if.master  bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occ;
    logic [XLEN-1:0] pcq [FIFO_DEPTH];
    logic [AW-1:0]   pcq_wr;
    logic [AW-1:0]   pcq_rd;

    fetch_entry_t    head;
    fetch_entry_t    push_entry_c;
    logic            credit_c;
    logic            issue_c;
    logic            resp_c;
    logic            push_c;
    logic            pop_c;

    // Buffered plus outstanding words may never exceed the buffer size, so a
    // response always has room to land.
    assign credit_c = ((CW+1)'(occ) + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);

    assign bus.imem_req_valid = rstn && !bus.redirect_valid && credit_c;
    assign bus.imem_req_addr  = pc;

    assign issue_c = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_c  = bus.imem_resp_valid;
    // A response in a redirect cycle belongs to the wrong path and is dropped.
    assign push_c  = resp_c && !bus.redirect_valid && (drop_cnt == '0);
    assign pop_c   = bus.id_valid && bus.id_ready && !bus.redirect_valid;

    assign push_entry_c = '{inst: bus.imem_resp_data, pc: pcq[pcq_rd]};

    // PC, outstanding-request bookkeeping and wrong-path drop counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
        end else begin
            if (bus.redirect_valid) pc <= bus.redirect_pc & ~XLEN'(3);
            else if (issue_c)       pc <= pc + XLEN'(4);

            if (issue_c) pcq_wr <= pcq_wr + AW'(1);
            if (resp_c)  pcq_rd <= pcq_rd + AW'(1);

            inflight <= inflight + CW'(issue_c) - CW'(resp_c);

            // Everything still outstanding after this cycle is wrong-path.
            if (bus.redirect_valid)           drop_cnt <= inflight - CW'(resp_c);
            else if (resp_c && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Request PCs, consumed in order as responses return.
    always_ff @(posedge clk) begin
        if (issue_c) pcq[pcq_wr] <= pc;
    end

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (bus.redirect_valid),
        .push      (push_c),
        .push_data (push_entry_c),
        .pop       (pop_c),
        .occ       (occ),
        .head      (head)
    );

    assign bus.id_valid = (occ != '0);
    assign bus.id_inst  = bus.id_valid ? head.inst : INST_NOP;
    assign bus.id_pc    = bus.id_valid ? head.pc   : '0;

    resp_needs_inflight: assert property (
        @(posedge clk) disable iff (!rstn) bus.imem_resp_valid |-> (inflight != '0)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an in-order, fixed-latency memory model.
module tb_inst_fetch;
    import cpu_pkg::*;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;
    int   cyc;
    int   req_cnt;
    int   mem_lat;
    int   base;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } mreq_t;
    mreq_t mq[$];

    inst_fetch_if bus ();

    inst_fetch #(
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0003;
    endfunction

    // Memory: responses driven at the falling edge, requests sampled shortly after.
    initial begin
        cyc = 0;
        req_cnt = 0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                mq.delete();
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = 32'h0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_resp_valid = 1'b0;
            end
            #3;
            if (rstn && bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{cyc + mem_lat, bus.imem_req_addr});
                req_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) for the next decode slot, check it, let it be consumed.
    task automatic get_id(input logic [63:0] exp_pc);
        int n;
        n = 0;
        while (!bus.id_valid && n < 12) begin
            step();
            n++;
        end
        chk($sformatf("id_valid_for_%h", exp_pc), 64'(bus.id_valid), 64'd1);
        chk($sformatf("id_pc_for_%h", exp_pc), bus.id_pc, exp_pc);
        chk($sformatf("id_inst_for_%h", exp_pc), 64'(bus.id_inst), 64'(mem_word(exp_pc)));
        step();
    endtask

    task automatic redirect(input logic [63:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        #1;
        chk("no_req_in_redirect", 64'(bus.imem_req_valid), 64'd0);
        step();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic quiesce();
        bus.id_ready = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mem_lat = 1;
        rstn = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;

        // Reset values
        repeat (3) step();
        chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("rst_id_inst", 64'(bus.id_inst), 64'(INST_NOP));
        chk("rst_id_pc", bus.id_pc, 64'h0);
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);

        // Release: first request at RESET_PC, first instruction two cycles later
        rstn = 1'b1;
        #1;
        chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("first_req_addr", bus.imem_req_addr, 64'h0);
        step();
        chk("id_empty_cycle1", 64'(bus.id_valid), 64'd0);
        step();
        chk("id_valid_cycle2", 64'(bus.id_valid), 64'd1);
        for (int i = 0; i < 6; i++) get_id(64'(i * 4));

        // Stall: exactly FIFO_DEPTH requests on the new path, then issue stops
        bus.id_ready = 1'b0;
        base = req_cnt;
        redirect(64'h200);
        repeat (10) step();
        chk("stall_issue_count", 64'(req_cnt - base), 64'd2);
        chk("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("stall_head_pc", bus.id_pc, 64'h200);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) get_id(64'h200 + 64'(i * 4));

        // Redirect with two requests in flight on a 3-cycle memory
        quiesce();
        mem_lat = 3;
        bus.id_ready = 1'b1;
        redirect(64'h40);
        step();
        step();
        redirect(64'h103);
        #1;
        chk("no_credit_while_dropping", 64'(bus.imem_req_valid), 64'd0);
        step();
        chk("aligned_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("aligned_req_addr", bus.imem_req_addr, 64'h100);
        get_id(64'h100);
        get_id(64'h104);

        // Redirect in a cycle carrying a response with req_ready high
        mem_lat = 1;
        for (int i = 0; i < 10 && !bus.imem_resp_valid; i++) step();
        chk("t4_resp_valid", 64'(bus.imem_resp_valid), 64'd1);
        chk("t4_req_ready", 64'(bus.imem_req_ready), 64'd1);
        redirect(64'h500);
        get_id(64'h500);
        get_id(64'h504);

        // 64-bit PC wrap
        redirect(64'hFFFF_FFFF_FFFF_FFF8);
        get_id(64'hFFFF_FFFF_FFFF_FFF8);
        get_id(64'hFFFF_FFFF_FFFF_FFFC);
        get_id(64'h0);
        get_id(64'h4);

        // Back-to-back redirects: the second wins
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h700;
        step();
        redirect(64'h800);
        get_id(64'h800);
        get_id(64'h804);

        // Reset with a full buffer
        quiesce();
        chk("full_before_reset", 64'(bus.id_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("midrst_id_inst", 64'(bus.id_inst), 64'(INST_NOP));
        chk("midrst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        step();
        rstn = 1'b1;
        bus.id_ready = 1'b1;
        #1;
        chk("restart_req_addr", bus.imem_req_addr, 64'h0);
        get_id(64'h0);
        get_id(64'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
